// File: rtl/inpcont_pkg.sv
// Shared constants, FSM state encoding and XY routing helper for the router input-port controller.
package inpcont_pkg;

  localparam int DATAW   = 15;
  localparam int ADDRW   = 1;
  localparam int PORTW   = 2;
  localparam int PORT    = 4;
  localparam int PORT_P1 = 5;

  localparam logic Enable_ = 1'b0;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  localparam logic [1:0] FLIT_HT   = 2'b11;

  localparam logic [PORTW:0] PORT_LOCAL = 3'd0;
  localparam logic [PORTW:0] PORT_NORTH = 3'd1;
  localparam logic [PORTW:0] PORT_EAST  = 3'd2;
  localparam logic [PORTW:0] PORT_SOUTH = 3'd3;
  localparam logic [PORTW:0] PORT_WEST  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_XFER = 2'b10
  } state_e;

  function automatic logic is_head(input logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_HT);
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_HT);
  endfunction

  // X is resolved completely before Y is considered.
  function automatic logic [PORTW:0] xy_route(input logic [ADDRW:0] dst_x,
                                              input logic [ADDRW:0] dst_y,
                                              input logic [ADDRW:0] my_x,
                                              input logic [ADDRW:0] my_y);
    logic [PORTW:0] p;
    if (dst_x > my_x) begin
      p = PORT_EAST;
    end else if (dst_x < my_x) begin
      p = PORT_WEST;
    end else if (dst_y > my_y) begin
      p = PORT_SOUTH;
    end else if (dst_y < my_y) begin
      p = PORT_NORTH;
    end else begin
      p = PORT_LOCAL;
    end
    return p;
  endfunction

endpackage

// File: rtl/inpcont_fifo.sv
// Flit FIFO for the input port: pointers carry an extra wrap bit to tell full from empty.
module inpcont_fifo
  import inpcont_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr_s, do_rd_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd_s   = rd_en_i & ~empty_o;
  assign do_wr_s   = wr_en_i & (~full_o | do_rd_s);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset discards any buffered flits.
  always_ff @(posedge clk) begin
    if (rst_ == Enable_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_wr_s) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/inpcont.sv
// Router input-port controller: buffers flits, XY-routes each head flit and
// runs the request/grant handshake with the output-side arbiters.
module inpcont
  import inpcont_pkg::*;
#(
  parameter logic [ADDRW:0] MYX   = {(ADDRW+1){1'b0}},
  parameter logic [ADDRW:0] MYY   = {(ADDRW+1){1'b0}},
  parameter int             DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [DATAW:0]     idata,
  input  logic               ivalid,
  output logic               iready,
  output logic [PORTW:0]     port,
  output logic               req,
  input  logic [PORT_P1-1:0] grt,
  input  logic [PORT:0]      oready,
  output logic [DATAW:0]     odata,
  output logic               ovalid
);

  state_e         state_q, state_d;
  logic [PORTW:0] port_q, port_d;
  logic           empty_s, full_s, push_s, pop_s, req_s, ovalid_s;
  logic [1:0]     top_type_s;
  logic [ADDRW:0] dst_x_s, dst_y_s;

  assign push_s     = ivalid & iready;
  assign iready     = ~full_s;
  assign top_type_s = odata[DATAW:DATAW-1];
  assign dst_x_s    = odata[2*ADDRW+1:ADDRW+1];
  assign dst_y_s    = odata[ADDRW:0];

  inpcont_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATAW+1)
  ) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .wr_en_i   (push_s),
    .wr_data_i (idata),
    .rd_en_i   (pop_s),
    .rd_data_o (odata),
    .full_o    (full_s),
    .empty_o   (empty_s)
  );

  // FSM state and latched output port.
  always_ff @(posedge clk) begin
    if (rst_ == Enable_) begin
      state_q <= ST_IDLE;
      port_q  <= PORT_LOCAL;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  // Next state, FIFO pop and handshake outputs.
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    pop_s    = 1'b0;
    req_s    = 1'b0;
    ovalid_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          if (is_head(top_type_s)) begin
            port_d  = xy_route(dst_x_s, dst_y_s, MYX, MYY);
            state_d = ST_REQ;
          end else begin
            pop_s = 1'b1;  // stray non-head flit: discard it
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        req_s = 1'b1;
        if (grt[port_q]) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_XFER: begin
        // req stays high so the arbiter keeps its grant locked.
        req_s    = 1'b1;
        ovalid_s = ~empty_s & oready[port_q];
        pop_s    = ovalid_s;
        if (ovalid_s && is_tail(top_type_s)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req    = req_s;
  assign ovalid = ovalid_s;
  assign port   = port_q;

endmodule

// File: tb/tb_inpcont.sv
// Directed bench for inpcont (MYX=1, MYY=1, DEPTH=4): routing table plus multi-cycle sequences.
module tb_inpcont;
  import inpcont_pkg::*;

  logic            clk = 1'b0;
  logic            rst_;
  logic [DATAW:0]  idata;
  logic            ivalid;
  logic            iready;
  logic [PORTW:0]  port;
  logic            req;
  logic [4:0]      grt;
  logic [4:0]      oready;
  logic [DATAW:0]  odata;
  logic            ovalid;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] dx;
    logic [1:0] dy;
    logic [9:0] pl;
    logic [2:0] exp_port;
  } vec_t;

  vec_t vecs [7];

  inpcont #(.MYX(2'd1), .MYY(2'd1), .DEPTH(4)) dut (
    .clk    (clk),
    .rst_   (rst_),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
    .port   (port),
    .req    (req),
    .grt    (grt),
    .oready (oready),
    .odata  (odata),
    .ovalid (ovalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] hflit(input logic [1:0] t, input logic [1:0] dx,
                                        input logic [1:0] dy, input logic [9:0] pl);
    return {t, pl, dx, dy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] f);
    idata  = f;
    ivalid = 1'b1;
    step();
    ivalid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (req !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check(name, {31'd0, req}, 32'd1);
  endtask

  logic [15:0] f, a, b;
  logic [15:0] pkt [4];
  int k;

  initial begin
    vecs[0] = '{2'd3, 2'd1, 10'h101, 3'd2};
    vecs[1] = '{2'd0, 2'd3, 10'h102, 3'd4};
    vecs[2] = '{2'd1, 2'd3, 10'h103, 3'd3};
    vecs[3] = '{2'd1, 2'd0, 10'h104, 3'd1};
    vecs[4] = '{2'd1, 2'd1, 10'h105, 3'd0};
    vecs[5] = '{2'd2, 2'd0, 10'h106, 3'd2};
    vecs[6] = '{2'd0, 2'd0, 10'h107, 3'd4};

    rst_ = 1'b0; ivalid = 1'b0; idata = '0; grt = 5'b00000; oready = 5'b11111;
    step(); step();
    rst_ = 1'b1;
    #1;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("rst_iready", {31'd0, iready}, 32'd1);
    check("rst_port", {29'd0, port}, 32'd0);

    // Single head+tail flit, fastest path.
    f = hflit(2'b11, 2'd3, 2'd1, 10'h2a5);
    send(f);
    check("single_t1_req", {31'd0, req}, 32'd0);
    step();
    check("single_t2_req", {31'd0, req}, 32'd1);
    check("single_t2_port", {29'd0, port}, 32'd2);
    grt = 5'b00100;
    #1;
    check("single_t2_ovalid", {31'd0, ovalid}, 32'd0);
    step();
    grt = 5'b00000;
    #1;
    check("single_t3_ovalid", {31'd0, ovalid}, 32'd1);
    check("single_t3_odata", {16'd0, odata}, {16'd0, f});
    step();
    check("single_t4_req", {31'd0, req}, 32'd0);
    check("single_t4_ovalid", {31'd0, ovalid}, 32'd0);

    // Routing table; a grant on every other port must be ignored.
    for (int i = 0; i < 7; i++) begin
      f = hflit(2'b11, vecs[i].dx, vecs[i].dy, vecs[i].pl);
      send(f);
      wait_req("tbl_req");
      check("tbl_port", {29'd0, port}, {29'd0, vecs[i].exp_port});
      grt = 5'h1f ^ (5'b00001 << vecs[i].exp_port);
      step();
      check("tbl_wrong_grt_req", {31'd0, req}, 32'd1);
      check("tbl_wrong_grt_ovalid", {31'd0, ovalid}, 32'd0);
      grt = 5'b00001 << vecs[i].exp_port;
      step();
      grt = 5'b00000;
      #1;
      check("tbl_ovalid", {31'd0, ovalid}, 32'd1);
      check("tbl_odata", {16'd0, odata}, {16'd0, f});
      step();
      check("tbl_req_drop", {31'd0, req}, 32'd0);
    end

    // 4-flit packet to (1,0) with oready[1] toggling.
    pkt[0] = hflit(2'b01, 2'd1, 2'd0, 10'h3c1);
    pkt[1] = {2'b00, 14'h1111};
    pkt[2] = {2'b00, 14'h2222};
    pkt[3] = {2'b10, 14'h3333};
    for (int i = 0; i < 4; i++) send(pkt[i]);
    wait_req("p4_req");
    check("p4_port", {29'd0, port}, 32'd1);
    grt = 5'b00010;
    step();
    grt = 5'b00000;
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      oready = (c % 2 == 0) ? 5'b00010 : 5'b11101;
      #1;
      check("p4_ovalid", {31'd0, ovalid}, (c % 2 == 0) ? 32'd1 : 32'd0);
      check("p4_req_held", {31'd0, req}, 32'd1);
      if (ovalid) begin
        check("p4_odata", {16'd0, odata}, {16'd0, pkt[k]});
        k++;
      end
      step();
    end
    oready = 5'b11111;
    check("p4_count", k, 32'd4);
    check("p4_req_drop", {31'd0, req}, 32'd0);

    // Fill the FIFO while no grant is given.
    pkt[0] = hflit(2'b01, 2'd3, 2'd1, 10'h0aa);
    pkt[1] = {2'b00, 14'h0b0b};
    pkt[2] = {2'b00, 14'h0c0c};
    pkt[3] = {2'b10, 14'h0d0d};
    for (int i = 0; i < 4; i++) begin
      check("fill_iready_pre", {31'd0, iready}, 32'd1);
      send(pkt[i]);
    end
    check("fill_iready_full", {31'd0, iready}, 32'd0);
    idata = hflit(2'b11, 2'd0, 2'd0, 10'h3ff);
    ivalid = 1'b1;
    step(); step();
    ivalid = 1'b0;
    check("fill_iready_still", {31'd0, iready}, 32'd0);
    check("fill_req", {31'd0, req}, 32'd1);
    check("fill_port", {29'd0, port}, 32'd2);
    grt = 5'b00100;
    step();
    grt = 5'b00000;
    check("fill_first_xfer_iready", {31'd0, iready}, 32'd0);
    check("fill_first_ovalid", {31'd0, ovalid}, 32'd1);
    check("fill_first_odata", {16'd0, odata}, {16'd0, pkt[0]});
    step();
    check("fill_iready_after_pop", {31'd0, iready}, 32'd1);
    k = 1;
    for (int c = 0; c < 8 && k < 4; c++) begin
      check("fill_ovalid", {31'd0, ovalid}, 32'd1);
      if (ovalid) begin
        check("fill_odata", {16'd0, odata}, {16'd0, pkt[k]});
        k++;
      end
      step();
    end
    check("fill_count", k, 32'd4);
    for (int c = 0; c < 3; c++) begin
      check("fill_no_5th", {31'd0, req}, 32'd0);
      step();
    end

    // Back-to-back packets: west then local, one idle cycle between requests.
    a = hflit(2'b11, 2'd0, 2'd1, 10'h011);
    b = hflit(2'b11, 2'd1, 2'd1, 10'h022);
    send(a);
    send(b);
    wait_req("b2b_req_a");
    check("b2b_port_a", {29'd0, port}, 32'd4);
    grt = 5'b10000;
    step();
    grt = 5'b00000;
    check("b2b_ovalid_a", {31'd0, ovalid}, 32'd1);
    check("b2b_odata_a", {16'd0, odata}, {16'd0, a});
    step();
    check("b2b_gap", {31'd0, req}, 32'd0);
    step();
    check("b2b_req_b", {31'd0, req}, 32'd1);
    check("b2b_port_b", {29'd0, port}, 32'd0);
    grt = 5'b00001;
    step();
    grt = 5'b00000;
    check("b2b_ovalid_b", {31'd0, ovalid}, 32'd1);
    check("b2b_odata_b", {16'd0, odata}, {16'd0, b});
    step();
    check("b2b_req_drop", {31'd0, req}, 32'd0);

    // Reset in the middle of a 3-flit packet.
    send(hflit(2'b01, 2'd3, 2'd1, 10'h155));
    send({2'b00, 14'h0555});
    send({2'b10, 14'h0666});
    wait_req("mid_req");
    grt = 5'b00100;
    step();
    grt = 5'b00000;
    check("mid_ovalid_head", {31'd0, ovalid}, 32'd1);
    step();
    oready = 5'b00000;
    #1;
    check("mid_stall_ovalid", {31'd0, ovalid}, 32'd0);
    check("mid_stall_req", {31'd0, req}, 32'd1);
    rst_ = 1'b0;
    step();
    rst_ = 1'b1;
    oready = 5'b11111;
    #1;
    check("mid_rst_req", {31'd0, req}, 32'd0);
    check("mid_rst_ovalid", {31'd0, ovalid}, 32'd0);
    check("mid_rst_iready", {31'd0, iready}, 32'd1);
    check("mid_rst_port", {29'd0, port}, 32'd0);
    f = hflit(2'b11, 2'd1, 2'd0, 10'h0f0);
    send(f);
    check("post_rst_t1_req", {31'd0, req}, 32'd0);
    step();
    check("post_rst_t2_req", {31'd0, req}, 32'd1);
    check("post_rst_port", {29'd0, port}, 32'd1);
    grt = 5'b00010;
    step();
    grt = 5'b00000;
    check("post_rst_ovalid", {31'd0, ovalid}, 32'd1);
    check("post_rst_odata", {16'd0, odata}, {16'd0, f});
    step();
    check("post_rst_req_drop", {31'd0, req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inpcont.md
# inpcont

Input-port controller for the NoC router. It buffers incoming flits in a small FIFO and computes the output port for each packet from its head flit using XY dimension-order routing. It then drives the `port_N`/`req_N` pair into the five output-side `muxcont` arbiters and streams the packet through the crossbar once granted. One instance sits on each of the router's five input ports; it is the requester end of the `muxcont` request/grant protocol.

## Interface
Parameters:
- MYX, 0: router X coordinate (`ADDRW+1` bits).
- MYY, 0: router Y coordinate.
- DEPTH, 4: FIFO depth in flits. Power of two, minimum 2.

Ports:
- clk  in  1  router clock; all state changes on the rising edge.
- rst_  in  1  synchronous reset, active-low (`Enable_`), sampled on the rising edge of clk.
- idata  in  `DATAW+1`  incoming flit. Bits [`DATAW:`DATAW-1] are the type: 01 head, 00 body, 10 tail, 11 head+tail. A head flit carries dst X in [2*`ADDRW+1:`ADDRW+1] and dst Y in [`ADDRW:0].
- ivalid  in  1  upstream flit valid.
- iready  out  1  FIFO can accept; transfer when ivalid & iready.
- port  out  `PORTW+1`  routed output port. Goes to every `muxcont` `port_N` slot for this input.
- req  out  1  packet request. Goes to every `muxcont` `req_N` slot for this input.
- grt  in  `PORT+1`  bit j = grant to this input from output port j's `muxcont`.
- oready  in  `PORT+1`  bit j = downstream of output j can take a flit.
- odata  out  `DATAW+1`  FIFO head flit toward the crossbar.
- ovalid  out  1  flit on odata is transferred this cycle.

## Operation
- Port numbering: 0 local, 1 north, 2 east, 3 south, 4 west.
- XY routing on the head flit, in this order of precedence:
  - dstX > MYX → 2
  - dstX < MYX → 4
  - dstY > MYY → 3
  - dstY < MYY → 1
  - otherwise → 0
- The FIFO uses rd/wr pointers of log2(DEPTH) bits plus an extra wrap bit.
  - Empty when the pointers are equal including the wrap bit.
  - Full when only the wrap bits differ.
  - iready = !full.
  - A write and a read in the same cycle are both honoured at full and at empty (a write to an empty FIFO is not readable the same cycle).
- State machine, 2-bit register:
  - IDLE: wait for FIFO not empty with a head flit at the top. Latch the routed port into `port_r` → REQ. A non-head flit at the top in IDLE is a protocol error: drop it (advance rd) and stay in IDLE.
  - REQ: req=1, port=`port_r`. When grt[`port_r`]=1 → XFER. `muxcont` registers `last` on this edge, so its `sel` is valid from the next cycle.
  - XFER: req=1 held, keeping `muxcont`'s grant locked through its hold path. ovalid = !empty & oready[`port_r`]; each ovalid pops one flit. When the popped flit is tail or head+tail → IDLE, and req drops in the following cycle.
- odata is always the FIFO top entry. It is combinational from the RAM and rd pointer.
- port holds `port_r` in every state. Only `req` qualifies it.

## Timing
- Reset values:
  - state IDLE, pointers 0, `port_r` 0.
  - req 0, ovalid 0, port 0.
  - iready 1 in the cycle after reset is sampled.
- Fastest path for a single-flit packet:
  - write at cycle t; at t+1 the flit is readable and IDLE→REQ.
  - req=1 at t+2; grt seen at t+2 → XFER at t+3.
  - ovalid at t+3; req=0 at t+4.
- Grant latency is unbounded. REQ waits indefinitely.
- A grant on any bit other than `port_r` is ignored.
- Back-to-back packets: IDLE lasts at least one cycle between packets, so req deasserts for at least one cycle and the `muxcont` can re-arbitrate.
- oready low in XFER stalls without leaving XFER. An empty FIFO in XFER (packet still arriving) also stalls.
- Reset mid-packet: everything returns to reset values on that edge and FIFO contents are discarded.

## Structure
- `define.h` holds `PORTW`, `PORT`, `PORT_P1`, `Enable_`, `DATAW`, `ADDRW`, the flit-type codes and the port-number constants. Add any of these that are missing.
- One sub-module, `fifo`: parameterised by DEPTH and width. It owns the pointers, full and empty. `inpcont` holds only the FSM and the routing logic.

## Test plan
- Reset with ivalid=0 → req=0, ovalid=0, iready=1, port=0.
- MYX=1, MYY=1; write a head+tail flit with dst (3,1); grt=5'b00100 at the first req cycle → port=2, exactly one ovalid cycle with the same flit, req low the next cycle.
- 4-flit packet to dst (1,0) with oready[1] toggling every cycle → port=1, 4 ovalid cycles matching the input order, req held until the tail pops.
- Fill the FIFO (DEPTH=4) with grt=0 → iready=0 after 4 writes, a 5th ivalid is not accepted; grant → iready=1 the cycle after the first pop.
- Two packets back-to-back, dst (0,1) then (1,1) → port 4 then 0, with a one-cycle req gap between them.
- Assert rst_=0 during XFER of a 3-flit packet → next cycle state IDLE, req=0, FIFO empty.
